path_replayer: RTL

//  Replays a motor path captured by the path recorder: takes the 105-bit packed record word
//  and re-drives M1/M2 oldest-first, each level held for the recorded duration in ticks.

---
 rtl/path_pkg.sv | 34 +++
 rtl/path_tick_timer.sv | 25 ++
 rtl/path_replayer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/path_pkg.sv
// Shared widths, record field offsets and FSM states for the path replayer.
// Optional build macro: PATH_REPLAY_LOOP_EN (see path_replayer).
package path_pkg;

  localparam int REC_W   = 7;
  localparam int DUR_W   = 4;
  localparam int NREC    = 15;
  localparam int DATA_W  = NREC * REC_W;
  localparam int DUR_LSB = 2;
  localparam int M2_BIT  = 1;
  localparam int M1_BIT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic logic [3:0] clamp_num(input logic [3:0] n);
    logic [4:0] w;
    w = {1'b0, n};
    return (w > 5'(NREC)) ? 4'(NREC) : n;
  endfunction

  // Returns {M2, M1} of record idx.
  function automatic logic [1:0] rec_motors(input logic [DATA_W-1:0] d, input logic [3:0] idx);
    return {d[int'(idx)*REC_W + M2_BIT], d[int'(idx)*REC_W + M1_BIT]};
  endfunction

  function automatic logic [DUR_W-1:0] rec_dur(input logic [DATA_W-1:0] d, input logic [3:0] idx);
    return d[int'(idx)*REC_W + DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/path_tick_timer.sv
// Free-running prescaler: one-cycle tick every TICK_CYCLES clocks, restarted by clr.
module path_tick_timer #(
  parameter int TICK_CYCLES = 7644
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [31:0] count;

  assign tick = (count == 32'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/path_replayer.sv
// Replays recorded M1/M2 levels oldest-first, each held for its recorded tick count.
// Define PATH_REPLAY_LOOP_EN to restart from the oldest record instead of finishing.
module path_replayer
  import path_pkg::*;
#(
  parameter int TICK_CYCLES = 7644,
  parameter int FINAL_TICKS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        num_rec,
  output logic              M1,
  output logic              M2,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rec_idx
);

  state_t            state;
  logic [DATA_W-1:0] snap;
  logic [3:0]        nsnap;
  logic [3:0]        ptr;
  logic [3:0]        nr;
  logic [3:0]        nxt_ptr;
  logic [31:0]       seg_dur;
  logic [31:0]       tcnt;
  logic              tick;
  logic              expire;
  logic              load;

  // Record p's level lasts as long as the duration stored in the next-newer record.
  function automatic logic [31:0] hold_for(input logic [DATA_W-1:0] d, input logic [3:0] p);
    return (p == 4'd0) ? 32'(FINAL_TICKS) : 32'(rec_dur(d, p - 4'd1));
  endfunction

  assign nr      = clamp_num(num_rec);
  assign nxt_ptr = (ptr == 4'd0) ? (nsnap - 4'd1) : (ptr - 4'd1);
  assign expire  = (state == PLAY) &&
                   ((seg_dur == 32'd0) || (tick && (tcnt == seg_dur - 32'd1)));

`ifdef PATH_REPLAY_LOOP_EN
  assign load = (state == PLAY) && !abort && expire;
`else
  assign load = (state == PLAY) && !abort && expire && (ptr != 4'd0);
`endif

  path_tick_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state != PLAY) || load),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      snap    <= '0;
      nsnap   <= '0;
      ptr     <= '0;
      seg_dur <= '0;
      tcnt    <= '0;
      M1      <= 1'b0;
      M2      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rec_idx <= '0;
    end else begin
      if ((state != PLAY) || load) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + 32'd1;
      end

      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            if (nr == 4'd0) begin
              done <= 1'b1;
            end else begin
              snap       <= data_in;
              nsnap      <= nr;
              ptr        <= nr - 4'd1;
              rec_idx    <= nr - 4'd1;
              {M2, M1}   <= rec_motors(data_in, nr - 4'd1);
              seg_dur    <= hold_for(data_in, nr - 4'd1);
              busy       <= 1'b1;
              state      <= PLAY;
            end
          end
        end

        PLAY: begin
          if (abort) begin
            {M2, M1} <= 2'b00;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (load) begin
            ptr      <= nxt_ptr;
            rec_idx  <= nxt_ptr;
            {M2, M1} <= rec_motors(snap, nxt_ptr);
            seg_dur  <= hold_for(snap, nxt_ptr);
          end else if (expire) begin
            {M2, M1} <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= FIN;
          end
        end

        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
